// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus/RAM geometry and the program loader state encoding.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT_DATA,
        WRITE,
        FINISH
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a program image into CPU RAM over the shared bus: MAR address, take one
// stream byte, RAM write, repeat; holds the CPU until a complete image is in place.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W        = CPU_DATA_W,
    parameter int ADDR_W        = CPU_ADDR_W,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              mar_load,
    output logic              ram_load,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_len != '0) begin
                        addr_d  = base_addr;
                        rem_d   = load_len;
                        hold_d  = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            ADDR: state_d = abort ? IDLE : WAIT_DATA;
            WAIT_DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    byte_d  = in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The RAM write of this cycle is a pure state decode, so it
                // still lands even when abort cuts the load short here.
                rem_d = rem_q - 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (rem_q == (ADDR_W+1)'(1)) begin
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ADDR;
                end
            end
            FINISH: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus-side outputs depend only on registered state/data, never on inputs.
    always_comb begin
        in_ready  = 1'b0;
        bus_drive = 1'b0;
        mar_load  = 1'b0;
        ram_load  = 1'b0;
        bus_out   = '0;
        case (state_q)
            ADDR: begin
                bus_drive = 1'b1;
                mar_load  = 1'b1;
                bus_out   = DATA_W'(addr_q);
            end
            WAIT_DATA: begin
                bus_drive = 1'b1;
                in_ready  = 1'b1;
            end
            WRITE: begin
                bus_drive = 1'b1;
                ram_load  = 1'b1;
                bus_out   = byte_q;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign cpu_hold = hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized load scenarios against a RAM/MAR environment model and a
// cycle-budget timing model of the loader.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid;
    logic [3:0] base_addr;
    logic [4:0] load_len;
    logic [7:0] in_data;
    logic       in_ready, bus_drive, mar_load, ram_load, cpu_hold, busy, done;
    logic [7:0] bus_out;

    prog_loader #(.DATA_W(8), .ADDR_W(4), .HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .load_len(load_len), .abort(abort), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .bus_out(bus_out),
        .bus_drive(bus_drive), .mar_load(mar_load), .ram_load(ram_load),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram[16];
    logic [7:0] exp_ram[16];
    logic [3:0] mar;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_bus_drive"}, bus_drive, 0);
        chk({tag, "_mar_load"}, mar_load, 0);
        chk({tag, "_ram_load"}, ram_load, 0);
        chk({tag, "_bus_out"}, bus_out, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
    endtask

    // abort_at: stream byte index whose WAIT_DATA gets aborted (-1 = none).
    task automatic run_load(input int base, input int len, input int gap_min, input int gap_max,
                            input int abort_at, input bit busy_start, input bit rst_write);
        logic [7:0] bytes[16];
        int gaps[16];
        int exp_done, i, cnt, rel, done_rel, nmar, nram, viol;
        bit finished, aborted, rst_pend;
        exp_done = 1;
        for (int k = 0; k < len; k++) begin
            bytes[k] = 8'($urandom);
            gaps[k]  = $urandom_range(gap_max, gap_min);
            exp_done += 3 + gaps[k];
        end
        i = 0; cnt = 0; done_rel = -1; nmar = 0; nram = 0; viol = 0;
        finished = 0; aborted = 0; rst_pend = 0;

        @(negedge clk);
        start = 1'b1; base_addr = 4'(base); load_len = 5'(len);
        @(negedge clk);
        rel = 1;
        while (!finished && rel < 400) begin
            if (rst_pend) begin
                chk_reset_outputs("rst_mid_write");
                rst = 1'b0;
                finished = 1;
            end else if (aborted) begin
                abort = 1'b0; in_valid = 1'b0;
                chk("abort_idle", busy, 0);
                chk("abort_hold", cpu_hold, 1);
                chk("abort_no_done", done, 0);
                finished = 1;
            end else if (done_rel >= 0) begin
                chk("hold_release", cpu_hold, 0);
                chk("idle_after_done", busy, 0);
                finished = 1;
            end else begin
                if (mar_load && ram_load) viol++;
                if ((mar_load || ram_load || in_ready) && !bus_drive) viol++;
                if (!bus_drive && bus_out != 8'h00) viol++;
                if (in_ready && bus_out != 8'h00) viol++;
                if (mar_load) begin mar = bus_out[3:0]; nmar++; end
                if (ram_load) begin ram[mar] = bus_out; nram++; end
                if (done) begin
                    done_rel = rel;
                    chk("done_time", rel, exp_done);
                    if (len != 0) chk("hold_at_done", cpu_hold, 1);
                end
                abort = 1'b0;
                if (busy_start && rel == 2) begin
                    start = 1'b1; base_addr = 4'd9; load_len = 5'd7;
                end else begin
                    start = 1'b0; base_addr = 4'($urandom); load_len = 5'($urandom);
                end
                if (in_ready) begin
                    if (abort_at == i) begin
                        abort = 1'b1; in_valid = 1'($urandom); in_data = 8'($urandom);
                        aborted = 1;
                    end else if (cnt == gaps[i]) begin
                        in_valid = 1'b1; in_data = bytes[i];
                        exp_ram[(base + i) % 16] = bytes[i];
                        i++; cnt = 0;
                    end else begin
                        in_valid = 1'b0; in_data = 8'($urandom); cnt++;
                    end
                end else begin
                    in_valid = 1'($urandom); in_data = 8'($urandom);
                end
                if (rst_write && ram_load) begin
                    rst = 1'b1; rst_pend = 1;
                end
            end
            @(negedge clk);
            rel++;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; rst = 1'b0;
        if (!finished) chk("timeout", 0, 1);
        chk("bus_invariants", viol, 0);
        if (!rst_write) begin
            if (abort_at >= 0) begin
                chk("abort_mar_count", nmar, abort_at + 1);
                chk("abort_ram_count", nram, abort_at);
                chk("abort_done_seen", done_rel, -1);
            end else begin
                chk("mar_count", nmar, len);
                chk("ram_count", nram, len);
            end
        end
        for (int a = 0; a < 16; a++)
            chk($sformatf("ram[%0d]", a), ram[a], exp_ram[a]);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin ram[a] = 8'h00; exp_ram[a] = 8'h00; end
        mar = 4'h0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        base_addr = 4'h0; load_len = 5'h0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        run_load(0, 3, 0, 0, -1, 0, 0);      // basic: done at 10
        run_load(5, 2, 4, 4, -1, 0, 0);      // backpressure
        run_load(3, 0, 0, 0, -1, 0, 0);      // zero length: done at 1
        run_load(14, 4, 0, 2, -1, 0, 0);     // wrap 14,15,0,1
        run_load(0, 16, 0, 0, -1, 0, 0);     // full depth: done at 49
        run_load(7, 5, 0, 1, 1, 1, 0);       // abort in 2nd WAIT_DATA, start while busy
        run_load(2, 6, 0, 3, -1, 1, 0);      // start while busy ignored
        for (int r = 0; r < 4; r++)
            run_load($urandom_range(15, 0), $urandom_range(16, 1), 0, 2, -1, 0, 0);
        run_load(4, 3, 0, 0, -1, 0, 1);      // reset during WRITE

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
